// File: rtl/tms_rom_arbiter.sv
// Shares a 1RW SRAM between a byte-wide core fetch port and a Wishbone slave. Core hits take 1 cycle,
// core misses 3, WB writes ack in 2 and reads in 3. Requesters hold their signals until ready/ack.
module tms_rom_arbiter (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        core_req_i,
  input  logic [10:0] core_addr_i,
  output logic        core_ready_o,
  output logic [7:0]  core_data_o,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        sram_csb_o,
  output logic        sram_web_o,
  output logic [3:0]  sram_wmask_o,
  output logic [8:0]  sram_addr_o,
  output logic [31:0] sram_din_o,
  input  logic [31:0] sram_dout_i
);

  typedef enum logic [2:0] {IDLE, C_ISS, C_CAP, W_ISS, W_CAP, W_ACK} state_e;

  state_e      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic [8:0]  tag_q, tag_d;
  logic        valid_q, valid_d;
  logic        last_wb_q, last_wb_d;
  logic        ready_q, ready_d;
  logic [7:0]  data_q, data_d;
  logic [31:0] wdat_q, wdat_d;

  logic [8:0]  core_word;
  logic [8:0]  wb_word;
  logic [4:0]  byte_lsb;
  logic        in_idle;
  logic        core_hit;
  logic        core_miss;
  logic        wb_pend;
  logic        grant_core;
  logic        grant_wb;
  logic        unused_adr;

  assign core_word  = core_addr_i[10:2];
  assign wb_word    = wbs_adr_i[10:2];
  assign byte_lsb   = {core_addr_i[1:0], 3'b000};
  assign unused_adr = ^{wbs_adr_i[31:17], wbs_adr_i[15:11], wbs_adr_i[1:0]};

  assign in_idle   = (state_q == IDLE);
  // The cycle that returns data ignores the still-held request so it cannot re-hit.
  assign core_hit  = in_idle & core_req_i & ~ready_q & valid_q & (tag_q == core_word);
  assign core_miss = in_idle & core_req_i & ~ready_q & ~core_hit;
  assign wb_pend   = in_idle & wbs_cyc_i & wbs_stb_i & wbs_adr_i[16] & ~wbs_ack_o;

  assign grant_core = core_miss & (~wb_pend | last_wb_q);
  assign grant_wb   = wb_pend & ~grant_core;

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    tag_d     = tag_q;
    valid_d   = valid_q;
    last_wb_d = last_wb_q;
    ready_d   = 1'b0;
    data_d    = data_q;
    wdat_d    = wdat_q;
    case (state_q)
      IDLE: begin
        if (core_hit) begin
          ready_d = 1'b1;
          data_d  = buf_q[byte_lsb +: 8];
        end
        if (grant_core) begin
          state_d   = C_ISS;
          last_wb_d = 1'b0;
        end else if (grant_wb) begin
          state_d   = W_ISS;
          last_wb_d = 1'b1;
        end
      end
      C_ISS: state_d = C_CAP;
      C_CAP: begin
        buf_d   = sram_dout_i;
        tag_d   = core_word;
        valid_d = 1'b1;
        ready_d = core_req_i;
        if (core_req_i) data_d = sram_dout_i[byte_lsb +: 8];
        state_d = IDLE;
      end
      W_ISS: begin
        if (wbs_we_i && (wb_word == tag_q)) valid_d = 1'b0;
        state_d = wbs_we_i ? W_ACK : W_CAP;
      end
      W_CAP: begin
        wdat_d  = sram_dout_i;
        state_d = W_ACK;
      end
      W_ACK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      last_wb_q <= 1'b1;
      ready_q   <= 1'b0;
      data_q    <= '0;
      wdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      last_wb_q <= last_wb_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
      wdat_q    <= wdat_d;
    end
  end

  assign core_ready_o = ready_q;
  assign core_data_o  = data_q;
  assign wbs_ack_o    = (state_q == W_ACK);
  assign wbs_dat_o    = wdat_q;

  assign sram_csb_o   = ~((state_q == C_ISS) | (state_q == W_ISS));
  assign sram_web_o   = (state_q == W_ISS) ? ~wbs_we_i : 1'b1;
  assign sram_addr_o  = (state_q == W_ISS) ? wb_word : core_word;
  assign sram_wmask_o = wbs_sel_i;
  assign sram_din_o   = wbs_dat_i;

endmodule

// File: doc/tms_rom_arbiter.md
TMS_ROM_ARBITER -- requirements
Module: tms_rom_arbiter

Interface
REQ-001 SHALL have ports wb_clk_i in 1 (single clock, all logic on rising edge) and wb_rst_ni in 1 (asynchronous, active-low reset).
REQ-002 SHALL have core fetch ports: core_req_i in 1, core_addr_i in 11 (byte address), core_ready_o out 1, core_data_o out 8.
REQ-003 SHALL have Wishbone slave ports: wbs_cyc_i in 1, wbs_stb_i in 1, wbs_we_i in 1, wbs_adr_i in 32, wbs_dat_i in 32, wbs_sel_i in 4, wbs_dat_o out 32, wbs_ack_o out 1.
REQ-004 SHALL have SRAM 1RW port ports: sram_csb_o out 1 (active low), sram_web_o out 1 (active low), sram_wmask_o out 4, sram_addr_o out 9 (word), sram_din_o out 32, sram_dout_i in 32 (valid the cycle after the csb-low cycle).

Function
REQ-005 SHALL implement FSM states IDLE, C_ISS, C_CAP, W_ISS, W_CAP, W_ACK; only C_ISS and W_ISS drive sram_csb_o=0.
REQ-006 SHALL drive sram_addr_o=core_addr_i[10:2] in C_ISS and wbs_adr_i[10:2] in W_ISS; sram_web_o=~wbs_we_i in W_ISS, 1 otherwise; sram_wmask_o=wbs_sel_i, sram_din_o=wbs_dat_i.
REQ-007 SHALL treat a Wishbone request as pending when wbs_cyc_i & wbs_stb_i & wbs_adr_i[16] & ~wbs_ack_o; requests with wbs_adr_i[16]=0 SHALL never be acked.
REQ-008 SHALL hold a one-word fetch buffer (32-bit data, 9-bit tag, valid bit).
REQ-009 Core hit (IDLE, core_req_i=1, valid=1, tag==core_addr_i[10:2]) SHALL assert core_ready_o for exactly one cycle on the next cycle, with core_data_o=buffer byte core_addr_i[1:0]; no SRAM access.
REQ-010 Core miss SHALL be arbitrated; when granted: IDLE->C_ISS->C_CAP->IDLE; C_CAP loads buffer, tag, valid=1; core_ready_o pulses in the cycle after C_CAP (miss latency 3 cycles from request in IDLE).
REQ-011 If core_req_i is low in C_CAP, buffer SHALL still fill but core_ready_o SHALL NOT pulse.
REQ-012 In the cycle core_ready_o=1, core_req_i SHALL be ignored (no duplicate hit).
REQ-013 Wishbone write: IDLE->W_ISS->W_ACK->IDLE; wbs_ack_o=1 for one cycle in W_ACK (ack 2 cycles after grant).
REQ-014 Wishbone read: IDLE->W_ISS->W_CAP->W_ACK->IDLE; W_CAP registers sram_dout_i into wbs_dat_o; wbs_dat_o held until next read capture.
REQ-015 A Wishbone write whose word address equals the buffer tag SHALL clear valid in W_ISS.
REQ-016 Arbitration in IDLE with both core miss and Wishbone pending SHALL grant the requester not granted last (1-bit last_grant, updated only on SRAM grants; hits do not update it); single requester is granted immediately.
REQ-017 A core hit and a Wishbone grant in the same IDLE cycle SHALL both proceed; the hit returns pre-write data.
REQ-018 The core SHALL hold core_req_i/core_addr_i stable until core_ready_o; the Wishbone master SHALL hold signals until wbs_ack_o.

Reset
REQ-019 While wb_rst_ni=0: state=IDLE, sram_csb_o=1, sram_web_o=1, core_ready_o=0, core_data_o=0, wbs_ack_o=0, wbs_dat_o=0, buffer valid=0, tag=0, last_grant=Wishbone (core wins first tie), asynchronously.
REQ-020 Reset asserted mid-transaction SHALL abort it with no ack/ready pulse; after release the first access is a miss.

Verification
REQ-021 Write wbs_adr_i=0x10008, dat=0x44332211, sel=0xF -> csb/web low 1 cycle at addr 2, ack 2 cycles after request; read back -> ack at 3 cycles, wbs_dat_o=0x44332211.
REQ-022 Core fetch addr 0x00A (word 2) after REQ-021 -> miss, ready 3 cycles later, data 0x33; then addr 0x009 -> ready next cycle, data 0x22, csb stays high.
REQ-023 Core miss and Wishbone read both pending in IDLE after reset -> core granted first, Wishbone next; repeated contention alternates grants.
REQ-024 Buffer holds word 2; Wishbone write 0x0000AA00 sel=0x2 to word 2; core fetch 0x009 -> miss, data 0xAA.
REQ-025 Assert wb_rst_ni=0 during C_CAP and during W_ISS -> csb high immediately, no ready/ack; after release, fetch of cached address is a miss.
REQ-026 Wishbone access with wbs_adr_i[16]=0 -> no SRAM access, wbs_ack_o stays 0; core fetches unaffected.
